// File: rtl/ebi_pkg.sv
// Shared definitions for the EBI bus master: widths, FSM state encoding,
// the transfer-acknowledge timeout and the counter reload helper.
package ebi_pkg;

    localparam int EBI_AW  = 24;   // bus address field width (A31..A8)
    localparam int WORD_AW = 22;   // internal word address width
    localparam int DW      = 32;   // data width
    localparam int BEW     = 4;    // byte-enable width

    // Maximum number of extra STROBE clocks spent waiting for ta_n
    localparam logic [7:0] TA_TIMEOUT = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } ebi_state_e;

    // Down-counter reload value for a phase lasting n clocks (n=0 is only
    // meaningful for TURN, which is then skipped entirely).
    function automatic logic [7:0] cyc_load(input int unsigned n);
        if (n == 0) begin
            return 8'd0;
        end
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/ebi_sync2.sv
// Single-bit two-flop synchronizer for an asynchronous level input.
// RST_VAL is the level the chain presents while in reset.
module ebi_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to let metastability settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ebi_master.sv
// EBI bus master: turns single-word read/write requests into timed
// SETUP / STROBE / HOLD / TURN bus cycles. All outputs are registered.
// Optional macro EBI_TA_WAIT_EN adds a ta_n wait-state input (with a
// timeout that raises err) that can stretch the STROBE phase.
module ebi_master
    import ebi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               wr,
    input  logic [WORD_AW-1:0] addr,
    input  logic [BEW-1:0]     be,
    input  logic [DW-1:0]      wdata,
    output logic               busy,
    output logic               ack,
    output logic [DW-1:0]      rdata,
    output logic               cs_n,
    output logic               oe_n,
    output logic [BEW-1:0]     we_n,
    output logic               rd_wr,
    output logic [EBI_AW-1:0]  ebi_addr,
    output logic [DW-1:0]      ebi_data_o,
    output logic               ebi_data_oe,
    input  logic [DW-1:0]      ebi_data_i
`ifdef EBI_TA_WAIT_EN
    ,
    input  logic               ta_n,
    output logic               err
`endif
);

    localparam logic [7:0] SETUP_LOAD  = cyc_load(SETUP_CYC);
    localparam logic [7:0] STROBE_LOAD = cyc_load(STROBE_CYC);
    localparam logic [7:0] HOLD_LOAD   = cyc_load(HOLD_CYC);
    localparam logic [7:0] TURN_LOAD   = cyc_load(TURN_CYC);

    ebi_state_e        state_q;
    logic [7:0]        cnt_q;
    logic              wr_q;
    logic [BEW-1:0]    be_q;
    logic [DW-1:0]     rbuf_q;
    logic              timeout_q;
    logic              busy_q;
    logic              ack_q;
    logic [DW-1:0]     rdata_q;
    logic              cs_n_q;
    logic              oe_n_q;
    logic [BEW-1:0]    we_n_q;
    logic              rd_wr_q;
    logic [EBI_AW-1:0] ebi_addr_q;
    logic [DW-1:0]     ebi_data_o_q;
    logic              ebi_data_oe_q;

    logic strobe_done;
    logic strobe_timeout;

`ifdef EBI_TA_WAIT_EN
    logic       ta_n_s;
    logic [7:0] ext_q;
    logic       err_q;

    ebi_sync2 #(.RST_VAL(1'b1)) u_ta_sync (
        .clk (clk),
        .rst (rst),
        .d   (ta_n),
        .q   (ta_n_s)
    );

    // Minimum strobe elapsed; leave on ta_n, or give up after the timeout.
    // Leaving while ta_n is still high can only mean the timeout fired.
    assign strobe_done    = (cnt_q == 8'd0) && (!ta_n_s || ext_q == TA_TIMEOUT);
    assign strobe_timeout = ta_n_s;
    assign err            = err_q;
`else
    assign strobe_done    = (cnt_q == 8'd0);
    assign strobe_timeout = 1'b0;
`endif

    // Bus cycle sequencer; every pin is updated here so nothing is combinational
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            wr_q          <= 1'b0;
            be_q          <= '0;
            rbuf_q        <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
            cs_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= '1;
            rd_wr_q       <= 1'b1;
            ebi_addr_q    <= '0;
            ebi_data_o_q  <= '0;
            ebi_data_oe_q <= 1'b0;
`ifdef EBI_TA_WAIT_EN
            ext_q         <= 8'd0;
            err_q         <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef EBI_TA_WAIT_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        wr_q       <= wr;
                        be_q       <= be;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        ebi_addr_q <= {addr, 2'b00};
                        rd_wr_q    <= ~wr;
                        if (wr) begin
                            ebi_data_o_q  <= wdata;
                            ebi_data_oe_q <= 1'b1;
                        end
                        cnt_q   <= SETUP_LOAD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        if (wr_q) begin
                            we_n_q <= ~be_q;
                        end else begin
                            oe_n_q <= 1'b0;
                        end
                        cnt_q   <= STROBE_LOAD;
                        state_q <= ST_STROBE;
`ifdef EBI_TA_WAIT_EN
                        ext_q   <= 8'd0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (strobe_done) begin
                        we_n_q    <= '1;
                        oe_n_q    <= 1'b1;
                        rbuf_q    <= ebi_data_i;
                        timeout_q <= strobe_timeout;
                        cnt_q     <= HOLD_LOAD;
                        state_q   <= ST_HOLD;
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
`ifdef EBI_TA_WAIT_EN
                    end else begin
                        ext_q <= ext_q + 8'd1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        ack_q         <= 1'b1;
                        cs_n_q        <= 1'b1;
                        rd_wr_q       <= 1'b1;
                        ebi_data_oe_q <= 1'b0;
                        if (!wr_q) begin
                            rdata_q <= timeout_q ? '0 : rbuf_q;
                        end
`ifdef EBI_TA_WAIT_EN
                        err_q <= timeout_q;
`endif
                        if (TURN_CYC == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= TURN_LOAD;
                            state_q <= ST_TURN;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_TURN: begin
                    if (cnt_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign cs_n        = cs_n_q;
    assign oe_n        = oe_n_q;
    assign we_n        = we_n_q;
    assign rd_wr       = rd_wr_q;
    assign ebi_addr    = ebi_addr_q;
    assign ebi_data_o  = ebi_data_o_q;
    assign ebi_data_oe = ebi_data_oe_q;

endmodule

// File: tb/tb_ebi_master.sv
// Self-checking bench for ebi_master: reset state, table of directed
// transfers, back-to-back requests, reset mid-cycle, then random transfers
// checked cycle by cycle against a timing model derived from phase lengths.
module tb_ebi_master;

    localparam int S  = 1;
    localparam int ST = 4;
    localparam int H  = 1;
    localparam int T  = 1;
    localparam int BUS_K = S + ST + H;       // cycle offset of the ack pulse
    localparam int LAST_K = BUS_K + T;       // first idle cycle after the transfer

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [21:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        cs_n;
    logic        oe_n;
    logic [3:0]  we_n;
    logic        rd_wr;
    logic [23:0] ebi_addr;
    logic [31:0] ebi_data_o;
    logic        ebi_data_oe;
    logic [31:0] ebi_data_i;
`ifdef EBI_TA_WAIT_EN
    logic        ta_n = 1'b0;
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ebi_master #(
        .SETUP_CYC  (S),
        .STROBE_CYC (ST),
        .HOLD_CYC   (H),
        .TURN_CYC   (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wr          (wr),
        .addr        (addr),
        .be          (be),
        .wdata       (wdata),
        .busy        (busy),
        .ack         (ack),
        .rdata       (rdata),
        .cs_n        (cs_n),
        .oe_n        (oe_n),
        .we_n        (we_n),
        .rd_wr       (rd_wr),
        .ebi_addr    (ebi_addr),
        .ebi_data_o  (ebi_data_o),
        .ebi_data_oe (ebi_data_oe),
        .ebi_data_i  (ebi_data_i)
`ifdef EBI_TA_WAIT_EN
        ,
        .ta_n        (ta_n),
        .err         (err)
`endif
    );

    typedef struct {
        logic        w;
        logic [21:0] a;
        logic [3:0]  b;
        logic [31:0] wd;
        logic [31:0] din;
        logic [23:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected {cs_n, oe_n, we_n, rd_wr, data_oe, ack, busy} k cycles after acceptance
    function automatic logic [9:0] exp_ctrl(input int k, input logic w, input logic [3:0] we_strb);
        logic       in_bus;
        logic       strobe;
        logic [3:0] we;
        in_bus = (k < BUS_K);
        strobe = (k >= S) && (k < S + ST);
        we     = (strobe && w) ? we_strb : 4'hF;
        return {!in_bus, !(strobe && !w), we, in_bus ? !w : 1'b1,
                in_bus && w, k == BUS_K, k < BUS_K + T};
    endfunction

    // One complete transfer from IDLE back to IDLE, compared every cycle
    task automatic run_txn(input logic w, input logic [21:0] a, input logic [3:0] b,
                           input logic [31:0] wd, input logic [31:0] din,
                           input logic [23:0] exp_addr, input logic [3:0] exp_we,
                           input logic [31:0] old_rd, input logic [31:0] new_rd);
        int cs_low = 0;
        int n_ack  = 0;
        wr = w; addr = a; be = b; wdata = wd; ebi_data_i = din; req = 1'b1;
        @(posedge clk); #1;
        // Scramble request inputs after acceptance; they must be ignored
        req = 1'b0; wr = ~w; addr = 22'($urandom); be = 4'($urandom); wdata = $urandom;
        for (int k = 0; k <= LAST_K; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk($sformatf("ctrl k=%0d", k), 64'({cs_n, oe_n, we_n, rd_wr, ebi_data_oe, ack, busy}),
                64'(exp_ctrl(k, w, exp_we)));
            chk($sformatf("ebi_addr k=%0d", k), 64'(ebi_addr), 64'(exp_addr));
            if (w && k < BUS_K) chk($sformatf("ebi_data_o k=%0d", k), 64'(ebi_data_o), 64'(wd));
            chk($sformatf("rdata k=%0d", k), 64'(rdata), 64'((k >= BUS_K) ? new_rd : old_rd));
            if (!cs_n) cs_low++;
            if (ack) n_ack++;
            // Read data was sampled at the edge closing STROBE; change it now
            if (k == S + ST) ebi_data_i = $urandom;
        end
        chk("cs_n low cycles", 64'(cs_low), 64'(BUS_K));
        chk("ack pulses", 64'(n_ack), 64'd1);
        $display("txn %s addr=%h be=%h wdata=%h rdata=%h", w ? "WR" : "RD", a, b, wd, rdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] last_rd;
        int          ack_cyc[$];
        int          cs_low;

        vecs[0] = '{1'b1, 22'h0012AB, 4'hF, 32'hDEADBEEF, 32'h0,         24'h004AAC, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 22'h3FFFFF, 4'h0, 32'h0,        32'hA5A50F0F,  24'hFFFFFC, 4'hF, 32'hA5A50F0F};
        vecs[2] = '{1'b1, 22'h000100, 4'b0101, 32'h11223344, 32'h0,      24'h000400, 4'b1010, 32'hA5A50F0F};
        vecs[3] = '{1'b1, 22'h2AAAAA, 4'h0, 32'hCAFEF00D, 32'h0,         24'hAAAAA8, 4'hF, 32'hA5A50F0F};
        vecs[4] = '{1'b0, 22'h000000, 4'hF, 32'h0,        32'h12345678,  24'h000000, 4'hF, 32'h12345678};

        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0; ebi_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctrl", 64'({cs_n, oe_n, we_n, rd_wr, ebi_data_oe, ack, busy}), 64'h3F8);
        chk("reset ebi_addr", 64'(ebi_addr), 64'h0);
        chk("reset ebi_data_o", 64'(ebi_data_o), 64'h0);
        chk("reset rdata", 64'(rdata), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        last_rd = 32'h0;
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].din,
                    vecs[i].exp_addr, vecs[i].exp_we, last_rd, vecs[i].exp_rdata);
            last_rd = vecs[i].exp_rdata;
        end

        // req held high for three transfers, dropped in the third ack cycle
        wr = 1'b1; addr = 22'h000055; be = 4'hF; wdata = 32'h0BADF00D; req = 1'b1;
        cs_low = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (!cs_n) cs_low++;
            if (ack) begin
                ack_cyc.push_back(c);
                if (ack_cyc.size() == 3) req = 1'b0;
            end
        end
        chk("b2b ack count", 64'(ack_cyc.size()), 64'd3);
        if (ack_cyc.size() >= 3) begin
            chk("b2b first ack", 64'(ack_cyc[0]), 64'(BUS_K));
            chk("b2b period 1", 64'(ack_cyc[1] - ack_cyc[0]), 64'(BUS_K + T + 1));
            chk("b2b period 2", 64'(ack_cyc[2] - ack_cyc[1]), 64'(BUS_K + T + 1));
        end
        chk("b2b cs_n low total", 64'(cs_low), 64'(3 * BUS_K));
        chk("b2b busy after", 64'(busy), 64'd0);
        $display("txn B2B acks=%0d cs_low=%0d", ack_cyc.size(), cs_low);

        // Reset in the second STROBE clock of a write
        wr = 1'b1; addr = 22'h001234; be = 4'hF; wdata = 32'h5555AAAA; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid strobe we_n", 64'(we_n), 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid reset ctrl", 64'({cs_n, oe_n, we_n, rd_wr, ebi_data_oe, ack, busy}), 64'h3F8);
        chk("mid reset ebi_addr", 64'(ebi_addr), 64'h0);
        chk("mid reset ebi_data_o", 64'(ebi_data_o), 64'h0);
        chk("mid reset rdata", 64'(rdata), 64'h0);
        rst = 1'b0;
        begin
            int n_ack = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (ack || busy) n_ack++;
            end
            chk("no ack/busy after reset", 64'(n_ack), 64'd0);
        end
        $display("txn RESET mid-strobe");
        run_txn(1'b0, 22'h000ABC, 4'hF, 32'h0, 32'hFEEDC0DE, 24'h002AF0, 4'hF, 32'h0, 32'hFEEDC0DE);
        last_rd = 32'hFEEDC0DE;

        // Random transfers against the model
        for (int i = 0; i < 24; i++) begin
            logic        w;
            logic [21:0] a;
            logic [3:0]  b;
            logic [31:0] wd;
            logic [31:0] din;
            logic [31:0] new_rd;
            w   = 1'($urandom);
            a   = 22'($urandom);
            b   = 4'($urandom);
            wd  = $urandom;
            din = $urandom;
            new_rd = w ? last_rd : din;
            run_txn(w, a, b, wd, din, 24'(a) * 24'd4, w ? ~b : 4'hF, last_rd, new_rd);
            last_rd = new_rd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
